// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory-port arbiter: owner codes,
// arbiter states and the default watchdog limit.
package mem_port_arbiter_pkg;

   // Default number of cycles a granted access may wait for ack
   localparam int unsigned TIMEOUT_DEFAULT = 32'd1023;

   // Owner encoding reported on owner_o
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_I    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;

   // Arbiter states
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2
   } arb_state_e;

   // Map an arbiter state onto the owner code shown on the status port
   function automatic logic [1:0] state_to_owner(arb_state_e st);
      logic [1:0] own;
      case (st)
         S_GRANT_I: own = OWN_I;
         S_GRANT_D: own = OWN_D;
         S_IDLE:    own = OWN_NONE;
         default:   own = OWN_NONE;
      endcase
      return own;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU-side (I and D masters) and MMU-side signals of the
// memory-port arbiter. The arbiter uses the slave view; whatever drives
// the masters and the MMU uses the master view.
interface mem_port_arbiter_if;

   // Instruction-fetch master
   logic [31:0] i_addr_i;
   logic        i_rd_i;
   logic [31:0] i_data_o;
   logic        i_ack_o;
   logic        i_err_o;

   // Load/store master
   logic [31:0] d_addr_i;
   logic [31:0] d_data_i;
   logic        d_we_i;
   logic        d_rd_i;
   logic [31:0] d_data_o;
   logic        d_ack_o;
   logic        d_err_o;

   // MMU virtual-address port
   logic [31:0] v_addr_o;
   logic [31:0] v_data_o;
   logic        v_we_o;
   logic        v_rd_o;
   logic [31:0] v_data_i;
   logic        v_ack_i;
   logic        page_fault_i;

   // Status
   logic [1:0]  owner_o;

   modport slave (
      input  i_addr_i, i_rd_i,
      input  d_addr_i, d_data_i, d_we_i, d_rd_i,
      input  v_data_i, v_ack_i, page_fault_i,
      output i_data_o, i_ack_o, i_err_o,
      output d_data_o, d_ack_o, d_err_o,
      output v_addr_o, v_data_o, v_we_o, v_rd_o,
      output owner_o
   );

   modport master (
      output i_addr_i, i_rd_i,
      output d_addr_i, d_data_i, d_we_i, d_rd_i,
      output v_data_i, v_ack_i, page_fault_i,
      input  i_data_o, i_ack_o, i_err_o,
      input  d_data_o, d_ack_o, d_err_o,
      input  v_addr_o, v_data_o, v_we_o, v_rd_o,
      input  owner_o
   );

endinterface

// File: rtl/mem_port_arbiter_access_watchdog.sv
// Access watchdog: counts cycles an access has been waiting and flags
// expiry once the count reaches TIMEOUT. The count holds at the limit
// until cleared.
module access_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,        // asynchronous, active-low
   input  logic clr_i,      // restart counting from zero
   input  logic en_i,       // count this cycle
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise advance while enabled and below the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing the MMU virtual-address port between the
// instruction-fetch unit (I) and the load/store unit (D). Round-robin
// between simultaneous requests, grant held until ack, page fault or
// watchdog expiry. The granted master's signals are mirrored onto v_*
// combinationally; acks pass straight through to the owner.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic              clk,
   input logic              rst,   // asynchronous, active-low
   mem_port_arbiter_if.slave bus
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_d_q;    // 1: D was served last, so I is favoured next
   logic       last_d_d;
   logic       data_en_q;   // read-data routing enabled once out of reset
   logic       data_en_d;

   logic        i_req_s;
   logic        d_req_s;
   logic        expired_s;
   logic        wd_clr_s;
   logic        wd_en_s;

   logic [31:0] v_addr_s;
   logic [31:0] v_data_s;
   logic        v_we_s;
   logic        v_rd_s;
   logic        i_ack_s;
   logic        i_err_s;
   logic        d_ack_s;
   logic        d_err_s;

   assign i_req_s = bus.i_rd_i;
   assign d_req_s = bus.d_we_i | bus.d_rd_i;

   // Next state, round-robin pointer and port mux for the current owner
   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      v_addr_s = 32'd0;
      v_data_s = 32'd0;
      v_we_s   = 1'b0;
      v_rd_s   = 1'b0;
      i_ack_s  = 1'b0;
      i_err_s  = 1'b0;
      d_ack_s  = 1'b0;
      d_err_s  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_req_s && d_req_s) begin
               state_d = last_d_q ? S_GRANT_I : S_GRANT_D;
            end else if (i_req_s) begin
               state_d = S_GRANT_I;
            end else if (d_req_s) begin
               state_d = S_GRANT_D;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_GRANT_I: begin
            v_addr_s = bus.i_addr_i;
            v_rd_s   = bus.i_rd_i & ~expired_s;
            if (bus.page_fault_i) begin
               // Fault beats a coincident ack
               i_err_s  = 1'b1;
               last_d_d = 1'b0;
               state_d  = S_IDLE;
            end else if (bus.v_ack_i) begin
               // Ack beats a coincident timeout; hand over without a bubble.
               // I is not regranted here since its request is still stale-high.
               i_ack_s  = 1'b1;
               last_d_d = 1'b0;
               state_d  = d_req_s ? S_GRANT_D : S_IDLE;
            end else if (expired_s) begin
               i_err_s  = 1'b1;
               last_d_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               state_d  = S_GRANT_I;
            end
         end

         S_GRANT_D: begin
            v_addr_s = bus.d_addr_i;
            v_data_s = bus.d_data_i;
            v_we_s   = bus.d_we_i & ~expired_s;
            v_rd_s   = bus.d_rd_i & ~expired_s;
            if (bus.page_fault_i) begin
               d_err_s  = 1'b1;
               last_d_d = 1'b1;
               state_d  = S_IDLE;
            end else if (bus.v_ack_i) begin
               d_ack_s  = 1'b1;
               last_d_d = 1'b1;
               state_d  = i_req_s ? S_GRANT_I : S_IDLE;
            end else if (expired_s) begin
               d_err_s  = 1'b1;
               last_d_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d  = S_GRANT_D;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read-data routing turns on after the first clock out of reset
   always_comb begin
      data_en_d = 1'b1;
   end

   // State, pointer and data-enable registers; reset favours I
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         last_d_q  <= 1'b1;
         data_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         data_en_q <= data_en_d;
      end
   end

   // Watchdog restarts whenever ownership changes and runs while granted
   assign wd_clr_s = (state_q == S_IDLE) || (state_d != state_q);
   assign wd_en_s  = (state_q != S_IDLE);

   access_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr_s),
      .en_i      (wd_en_s),
      .expired_o (expired_s)
   );

   assign bus.v_addr_o = v_addr_s;
   assign bus.v_data_o = v_data_s;
   assign bus.v_we_o   = v_we_s;
   assign bus.v_rd_o   = v_rd_s;
   assign bus.i_ack_o  = i_ack_s;
   assign bus.i_err_o  = i_err_s;
   assign bus.d_ack_o  = d_ack_s;
   assign bus.d_err_o  = d_err_s;
   assign bus.i_data_o = data_en_q ? bus.v_data_i : 32'd0;
   assign bus.d_data_o = data_en_q ? bus.v_data_i : 32'd0;
   assign bus.owner_o  = state_to_owner(state_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized master/MMU traffic, all compared every cycle against a
// transaction-level model of ownership, fairness and watchdog rules.
module tb_mem_port_arbiter;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if mif ();

   mem_port_arbiter #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus state (what the masters and the MMU drive)
   logic [31:0] i_addr, d_addr, d_data, v_data;
   bit          i_rd, d_we, d_rd, v_data_rand, rand_mode;
   int          ack_at, pf_at;   // wait index at which MMU acks / faults, -1 = never

   // Reference model: owner 0 none / 1 I / 2 D, who was served last, cycles waited
   int m_owner, m_last, m_wait;
   bit new_grant, i_done, d_done;

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=0x%08h exp=0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_last = 2; m_wait = 0;
      new_grant = 0; i_done = 0; d_done = 0;
   endtask

   task automatic check_zero(string tag);
      check_val({tag, "_owner"}, mif.owner_o, 32'd0);
      check_val({tag, "_vaddr"}, mif.v_addr_o, 32'd0);
      check_val({tag, "_vdata"}, mif.v_data_o, 32'd0);
      check_val({tag, "_vwe"},   mif.v_we_o, 32'd0);
      check_val({tag, "_vrd"},   mif.v_rd_o, 32'd0);
      check_val({tag, "_iack"},  mif.i_ack_o, 32'd0);
      check_val({tag, "_ierr"},  mif.i_err_o, 32'd0);
      check_val({tag, "_dack"},  mif.d_ack_o, 32'd0);
      check_val({tag, "_derr"},  mif.d_err_o, 32'd0);
      check_val({tag, "_idata"}, mif.i_data_o, 32'd0);
      check_val({tag, "_ddata"}, mif.d_data_o, 32'd0);
   endtask

   task automatic zero_inputs();
      i_rd = 0; d_we = 0; d_rd = 0;
      mif.i_addr_i = 32'd0; mif.i_rd_i = 1'b0;
      mif.d_addr_i = 32'd0; mif.d_data_i = 32'd0;
      mif.d_we_i = 1'b0; mif.d_rd_i = 1'b0;
      mif.v_ack_i = 1'b0; mif.page_fault_i = 1'b0;
      mif.v_data_i = 32'd0;
   endtask

   // One clock: drive at posedge+1, compare at negedge, advance the model
   task automatic step();
      bit a, f, expd, dq, ack_ok, err, other_req;
      int other;
      logic [31:0] vd, ea, ed;
      bit ewe, erd;
      @(posedge clk);
      #1;
      a  = (m_owner != 0) && (m_wait == ack_at);
      f  = (m_owner != 0) && (m_wait == pf_at);
      vd = v_data_rand ? $urandom() : v_data;
      mif.i_addr_i = i_addr; mif.i_rd_i = i_rd;
      mif.d_addr_i = d_addr; mif.d_data_i = d_data;
      mif.d_we_i = d_we; mif.d_rd_i = d_rd;
      mif.v_ack_i = a; mif.page_fault_i = f; mif.v_data_i = vd;
      @(negedge clk);

      dq     = d_we | d_rd;
      expd   = (m_owner != 0) && (m_wait == TMO);
      ack_ok = (m_owner != 0) && a && !f;
      err    = (m_owner != 0) && (f || (expd && !a));
      ea = 32'd0; ed = 32'd0; ewe = 0; erd = 0;
      if (m_owner == 1) begin
         ea = i_addr; erd = i_rd && !expd;
      end else if (m_owner == 2) begin
         ea = d_addr; ed = d_data; ewe = d_we && !expd; erd = d_rd && !expd;
      end
      check_val("owner", mif.owner_o, m_owner);
      check_val("v_addr", mif.v_addr_o, ea);
      check_val("v_data", mif.v_data_o, ed);
      check_val("v_we", mif.v_we_o, ewe);
      check_val("v_rd", mif.v_rd_o, erd);
      check_val("i_ack", mif.i_ack_o, ack_ok && m_owner == 1);
      check_val("i_err", mif.i_err_o, err && m_owner == 1);
      check_val("d_ack", mif.d_ack_o, ack_ok && m_owner == 2);
      check_val("d_err", mif.d_err_o, err && m_owner == 2);
      check_val("i_data", mif.i_data_o, vd);
      check_val("d_data", mif.d_data_o, vd);

      new_grant = 0; i_done = 0; d_done = 0;
      if (m_owner == 0) begin
         if (i_rd && dq)  m_owner = (m_last == 1) ? 2 : 1;
         else if (i_rd)   m_owner = 1;
         else if (dq)     m_owner = 2;
         if (m_owner != 0) begin m_wait = 0; new_grant = 1; end
      end else if (ack_ok || err) begin
         if (m_owner == 1) i_done = 1; else d_done = 1;
         m_last    = m_owner;
         other     = 3 - m_owner;
         other_req = (other == 1) ? i_rd : dq;
         if (ack_ok && other_req) begin
            m_owner = other; m_wait = 0; new_grant = 1;
         end else begin
            m_owner = 0;
         end
      end else begin
         m_wait++;
      end
      if (i_done) i_rd = 0;
      if (d_done) begin d_we = 0; d_rd = 0; end
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      rst = 1'b0;
      i_addr = 32'd0; d_addr = 32'd0; d_data = 32'd0; v_data = 32'd0;
      v_data_rand = 1; rand_mode = 0; ack_at = -1; pf_at = -1;
      zero_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1 rst = 1'b1;

      // Simultaneous requests after reset: I first, then D with no bubble, then I again
      ack_at = 1;
      i_rd = 1; d_rd = 1; d_addr = 32'h0000_2000;
      step();
      step(); check_val("rr_first_i", mif.owner_o, 32'd1);
      step(); check_val("rr_i_ack", mif.i_ack_o, 32'd1);
      step(); check_val("rr_d_nobubble", mif.owner_o, 32'd2);
      step(); check_val("rr_d_ack", mif.d_ack_o, 32'd1);
      i_rd = 1; d_rd = 1;
      step(); check_val("rr_idle", mif.owner_o, 32'd0);
      step(); check_val("rr_second_i", mif.owner_o, 32'd1);
      run(5);

      // Lone I read with ack three cycles after v_rd rises
      ack_at = 3; v_data_rand = 0; v_data = 32'hDEAD_BEEF;
      i_addr = 32'h0000_1004; i_rd = 1;
      step(); check_val("t1_vrd_low", mif.v_rd_o, 32'd0);
      step(); check_val("t1_vrd_high", mif.v_rd_o, 32'd1);
      check_val("t1_vaddr", mif.v_addr_o, 32'h0000_1004);
      run(2);  check_val("t1_no_ack", mif.i_ack_o, 32'd0);
      step(); check_val("t1_ack", mif.i_ack_o, 32'd1);
      check_val("t1_data", mif.i_data_o, 32'hDEAD_BEEF);
      step(); check_val("t1_idle", mif.owner_o, 32'd0);
      v_data_rand = 1;

      // D write held until ack while I waits
      d_we = 1; d_rd = 0; d_addr = 32'h8000_0010; d_data = 32'h1234_5678;
      step();
      i_rd = 1; i_addr = 32'h0000_3000;
      for (int k = 0; k < 4; k++) begin
         step();
         check_val("t3_we", mif.v_we_o, 32'd1);
         check_val("t3_addr", mif.v_addr_o, 32'h8000_0010);
         check_val("t3_wdata", mif.v_data_o, 32'h1234_5678);
         check_val("t3_i_noack", mif.i_ack_o, 32'd0);
      end
      run(5);

      // Page fault on D together with ack: err only, then pending I granted
      d_rd = 1; d_addr = 32'h0000_4000;
      step();
      i_rd = 1; pf_at = 1; ack_at = 1;
      run(2);
      check_val("t4_derr", mif.d_err_o, 32'd1);
      check_val("t4_dack", mif.d_ack_o, 32'd0);
      pf_at = -1; ack_at = 0;
      step(); check_val("t4_derr_pulse", mif.d_err_o, 32'd0);
      step(); check_val("t4_i_next", mif.owner_o, 32'd1);
      step();

      // Watchdog: no ack, err on the 9th grant cycle with v_rd dropped
      ack_at = -1; pf_at = -1; i_rd = 1;
      step();
      for (int k = 1; k <= 9; k++) begin
         step();
         check_val("t5_ierr", mif.i_err_o, (k == 9) ? 32'd1 : 32'd0);
         check_val("t5_vrd", mif.v_rd_o, (k == 9) ? 32'd0 : 32'd1);
      end
      step();

      // Reset in the middle of a D grant, pointer favouring D beforehand
      d_rd = 1;
      run(3);
      check_val("t6_pre_owner", mif.owner_o, 32'd2);
      @(posedge clk); #2 rst = 1'b0;
      #1 check_zero("t6_async");
      zero_inputs();
      model_reset();
      @(posedge clk); #1 rst = 1'b1;
      i_rd = 1; d_rd = 1; ack_at = 0;
      step();
      step(); check_val("t6_first_i", mif.owner_o, 32'd1);
      run(3);

      // Randomized traffic
      rand_mode = 1;
      for (int c = 0; c < 4000; c++) begin
         if (!i_rd && ($urandom_range(0, 2) == 0)) begin
            i_rd = 1; i_addr = $urandom();
         end
         if (!(d_we || d_rd) && ($urandom_range(0, 2) == 0)) begin
            d_addr = $urandom(); d_data = $urandom();
            if ($urandom_range(0, 1) == 0) d_we = 1; else d_rd = 1;
         end
         if (new_grant) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: begin ack_at = $urandom_range(0, 3); pf_at = -1; end
               5:       begin pf_at = $urandom_range(0, 3); ack_at = -1; end
               6:       begin ack_at = $urandom_range(0, 3); pf_at = ack_at; end
               7:       begin ack_at = TMO; pf_at = -1; end
               8:       begin ack_at = -1; pf_at = -1; end
               default: begin ack_at = -1; pf_at = TMO; end
            endcase
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the single virtual-address port of the MMU between the instruction-fetch unit (I) and the load/store unit (D). It sits between the CPU core and the MMU. It grants the port to one master at a time with round-robin fairness and holds the grant until the access completes. It also terminates accesses that raise a page fault or exceed a watchdog limit.

## Interface
- TIMEOUT, 1023: maximum cycles a granted access may wait for ack before being aborted; counter width = $clog2(TIMEOUT+1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- i_addr_i  in  32  I virtual address
- i_rd_i  in  1  I read request (level, held until ack/err)
- i_data_o  out  32  I read data
- i_ack_o  out  1  I access complete
- i_err_o  out  1  I access aborted (fault or timeout), 1-cycle pulse
- d_addr_i  in  32  D virtual address
- d_data_i  in  32  D write data
- d_we_i  in  1  D write request (level)
- d_rd_i  in  1  D read request (level)
- d_data_o  out  32  D read data
- d_ack_o  out  1  D access complete
- d_err_o  out  1  D access aborted, 1-cycle pulse
- v_addr_o  out  32  to MMU virtual address
- v_data_o  out  32  to MMU write data
- v_we_o  out  1  to MMU write strobe
- v_rd_o  out  1  to MMU read strobe
- v_data_i  in  32  from MMU read data
- v_ack_i  in  1  from MMU ack (may be combinational from v_* outputs)
- page_fault_i  in  1  from MMU page fault
- owner_o  out  2  current owner: 0 none, 1 I, 2 D (debug/status)

## Operation
- States: S_IDLE, S_GRANT_I, S_GRANT_D. Reset → S_IDLE, priority pointer favours I.
- The request of I is i_rd_i. The request of D is d_we_i | d_rd_i.
- S_IDLE: if exactly one request is active, grant it. If both are active, grant the master not served last (round-robin). With no request, stay in S_IDLE.
- In S_GRANT_x, the v_* outputs mirror master x combinationally.
- When I owns the port: v_we_o = 0 and v_data_o = 0.
- In S_IDLE: v_addr_o, v_data_o, v_we_o and v_rd_o are all 0.
- v_data_i is routed to both i_data_o and d_data_o. Only the owner's ack is qualified.
- x_ack_o = v_ack_i when in S_GRANT_x, otherwise 0.
- On ack in S_GRANT_x:
  - Record x as last served.
  - If the other master is requesting, go directly to S_GRANT_other (no bubble).
  - Otherwise go to S_IDLE.
  - Never regrant x on the ack cycle, because its request is still stale-high then.
- Page fault in S_GRANT_x:
  - Pulse x_err_o in the same cycle.
  - Suppress x_ack_o even if v_ack_i is also high.
  - Go to S_IDLE and mark x as last served.
- Watchdog:
  - The counter clears on every grant and increments each cycle in S_GRANT_x without ack.
  - When count == TIMEOUT: x_err_o pulses, the v_* strobes drop that cycle, and the state goes to S_IDLE.
- After err, the master must drop its request. A request still high in S_IDLE is treated as a new access.

## Timing
- Arbitration latency is 1 cycle: a request seen in S_IDLE at edge n is driven on v_* during cycle n+1.
- Ack path is combinational: v_ack_i → x_ack_o with zero latency.
- Back-to-back alternation costs 0 idle cycles. Repeated accesses by one master cost 1 idle cycle each.
- Simultaneous ack and page_fault: the fault wins (err, no ack).
- Simultaneous ack and timeout: the ack wins.
- Reset asserted mid-access:
  - State goes immediately to S_IDLE and all outputs go to 0.
  - The pointer returns to favour I.
  - The in-flight access is dropped without ack or err.
- Reset values of all outputs: every output 0 (owner_o = 0).

## Structure
- Shared package holds:
  - owner encoding constants (OWN_NONE = 0, OWN_I = 1, OWN_D = 2);
  - state constants S_IDLE, S_GRANT_I, S_GRANT_D;
  - the default TIMEOUT.
- One sub-module fits naturally: access_watchdog, which takes a clear input and an enable input and outputs an expired flag, parameterised by TIMEOUT. Everything else stays flat.

## Test plan
- I reads 0x00001004 alone:
  - v_rd_o rises 1 cycle after i_rd_i.
  - MMU acks 3 cycles later with data 0xDEADBEEF.
  - i_ack_o and i_data_o = 0xDEADBEEF appear the same cycle.
  - The state returns to S_IDLE.
- I and D request in the same cycle after reset:
  - I is granted first.
  - On I's ack, D is granted with no idle cycle.
  - A further simultaneous request goes to I.
- D writes 0x12345678 to 0x80000010:
  - v_we_o = 1, v_addr_o = 0x80000010 and v_data_o = 0x12345678 are held until ack.
  - I stays unacked throughout.
- Page fault on D access: d_err_o pulses for 1 cycle, d_ack_o stays 0, and the pending I access is granted next.
- Timeout with TIMEOUT = 8 and no ack: i_err_o pulses on the 9th grant cycle and v_rd_o drops that cycle.
- rst driven low mid-grant: all outputs are 0 asynchronously, and after release the first contested grant goes to I.
